// File: rtl/column_buffer_if.sv
// Pixel-in / column-out bus of the column buffer.
// The producer drives the i* side and the consumer reads the o* side.
interface column_buffer_if #(
    parameter int DATA_W = 8
);
    logic              iValid;
    logic              iSof;
    logic [DATA_W-1:0] iPixel;
    logic              oValid;
    logic [DATA_W-1:0] oNumA;
    logic [DATA_W-1:0] oNumB;
    logic [DATA_W-1:0] oNumC;
    logic [11:0]       oCol;
    logic              oEol;

    modport master (
        output iValid, iSof, iPixel,
        input  oValid, oNumA, oNumB, oNumC, oCol, oEol
    );

    modport slave (
        input  iValid, iSof, iPixel,
        output oValid, oNumA, oNumB, oNumC, oCol, oEol
    );
endinterface

// File: rtl/column_buffer.sv
// Two-line delay buffer that turns a raster pixel stream into vertical
// 3-pixel columns (y-2, y-1, y) for a downstream 3-input sorter.
module column_buffer #(
    parameter int LINE_W = 640,
    parameter int DATA_W = 8
) (
    input  logic           iClk,
    input  logic           iRst_n,
    column_buffer_if.slave bus
);
    localparam int              COL_W    = $clog2(LINE_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

    logic [DATA_W-1:0] r_line0 [LINE_W];
    logic [DATA_W-1:0] r_line1 [LINE_W];

    logic [COL_W-1:0]  r_col;
    logic [1:0]        r_row;
    logic              r_valid;
    logic [DATA_W-1:0] r_num_a;
    logic [DATA_W-1:0] r_num_b;
    logic [DATA_W-1:0] r_num_c;
    logic [11:0]       r_out_col;
    logic              r_eol;

    logic [COL_W-1:0]  w_col;
    logic [1:0]        w_row;
    logic              w_accept;

    // Effective position of the accepted pixel: start of frame restarts at (0,0)
    always_comb begin
        w_accept = bus.iValid;
        w_col    = r_col;
        w_row    = r_row;
        if (bus.iSof) begin
            w_col = {COL_W{1'b0}};
            w_row = 2'd0;
        end else begin
            w_col = r_col;
            w_row = r_row;
        end
    end

    // Line memories: shift the column down one line, read-before-write, never reset
    always_ff @(posedge iClk) begin
        if (iRst_n && w_accept) begin
            r_line1[w_col] <= r_line0[w_col];
            r_line0[w_col] <= bus.iPixel;
        end
    end

    // Counters and registered column outputs
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_col     <= {COL_W{1'b0}};
            r_row     <= 2'd0;
            r_valid   <= 1'b0;
            r_num_a   <= {DATA_W{1'b0}};
            r_num_b   <= {DATA_W{1'b0}};
            r_num_c   <= {DATA_W{1'b0}};
            r_out_col <= 12'd0;
            r_eol     <= 1'b0;
        end else if (w_accept) begin
            r_num_a   <= r_line1[w_col];
            r_num_b   <= r_line0[w_col];
            r_num_c   <= bus.iPixel;
            r_out_col <= 12'(w_col);
            r_eol     <= (w_col == LAST_COL);
            // Row counter alone decides validity, so stale memory is always masked
            r_valid   <= (w_row == 2'd2);
            if (w_col == LAST_COL) begin
                r_col <= {COL_W{1'b0}};
                r_row <= (w_row == 2'd2) ? 2'd2 : (w_row + 2'd1);
            end else begin
                r_col <= w_col + {{(COL_W-1){1'b0}}, 1'b1};
                r_row <= w_row;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.oValid = r_valid;
    assign bus.oNumA  = r_num_a;
    assign bus.oNumB  = r_num_b;
    assign bus.oNumC  = r_num_c;
    assign bus.oCol   = r_out_col;
    assign bus.oEol   = r_eol;
endmodule
